// File: rtl/ascon_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ascon_fsm_ctrl
// Purpose  : Sequencing controller for an Ascon encryption datapath. One
//            message is processed per start_i pulse: the 12-round
//            initialisation, one associated-data block, NB_BLOCKS-1 plaintext
//            blocks, and a 12-round finalisation that absorbs the last block.
//            The controller drives the state-register controls, the XOR
//            injection points, the round index, and the status flags.
// Ports    : clock_i          - rising-edge clock
//            resetb_i         - asynchronous active-low reset
//            start_i          - begin one encryption (sampled in IDLE only)
//            data_valid_i     - AD/plaintext block present on the data bus
//            data_ready_o     - controller is waiting for a block
//            select_o         - 1 = load external initial state
//            enable_o         - state register enable
//            xor_data_begin_o - XOR data block into the state (round start)
//            xor_key_begin_o  - XOR key into the state (finalisation start)
//            xor_key_end_o    - XOR key after the last 12-round permutation
//            xor_ext_end_o    - domain-separation XOR after the AD block
//            round_o          - round index for the round constant
//            block_o          - index of plaintext block being absorbed
//            cipher_valid_o   - ciphertext block available
//            tag_valid_o      - tag available
//            busy_o           - message in progress
//            done_o           - message complete (one cycle)
// Revision : 1.0 - initial release
// ============================================================================
module ascon_fsm_ctrl #(
  parameter int NB_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       select_o,
  output logic       enable_o,
  output logic       xor_data_begin_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_ext_end_o,
  output logic [3:0] round_o,
  output logic [3:0] block_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_AD_WAIT = 3'd2,
    S_AD      = 3'd3,
    S_PT_WAIT = 3'd4,
    S_PT      = 3'd5,
    S_FIN     = 3'd6,
    S_END     = 3'd7
  } state_t;

  localparam logic [3:0] c_first_round = 4'd0;
  localparam logic [3:0] c_mid_round   = 4'd6;   // first round of a 6-round permutation
  localparam logic [3:0] c_last_round  = 4'd11;
  localparam logic [3:0] c_last_block  = 4'(NB_BLOCKS - 1);

  state_t     r_state;
  state_t     w_nxt_state;
  logic [3:0] r_round;
  logic [3:0] w_nxt_round;
  logic [3:0] r_block;
  logic [3:0] w_nxt_block;

  // Output values decoded from the next state, registered alongside it so
  // every output comes straight from a flop.
  logic       w_data_ready;
  logic       w_select;
  logic       w_enable;
  logic       w_xor_data_begin;
  logic       w_xor_key_begin;
  logic       w_xor_key_end;
  logic       w_xor_ext_end;
  logic [3:0] w_round;
  logic [3:0] w_block;
  logic       w_cipher_valid;
  logic       w_tag_valid;
  logic       w_busy;
  logic       w_done;

  // --------------------------------------------------------------------------
  // Next-state and counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_round = r_round;
    w_nxt_block = r_block;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_nxt_state = S_INIT;
          w_nxt_round = c_first_round;
          w_nxt_block = 4'd0;
        end
      end
      S_INIT: begin
        if (r_round == c_last_round) begin
          w_nxt_state = S_AD_WAIT;
          w_nxt_round = c_first_round;
        end else begin
          w_nxt_round = r_round + 4'd1;
        end
      end
      S_AD_WAIT: begin
        if (data_valid_i) begin
          w_nxt_state = S_AD;
          w_nxt_round = c_mid_round;
        end
      end
      S_AD: begin
        if (r_round == c_last_round) begin
          w_nxt_state = S_PT_WAIT;
          w_nxt_round = c_first_round;
        end else begin
          w_nxt_round = r_round + 4'd1;
        end
      end
      S_PT_WAIT: begin
        // The final block is absorbed by the finalisation permutation.
        if (data_valid_i) begin
          if (r_block == c_last_block) begin
            w_nxt_state = S_FIN;
            w_nxt_round = c_first_round;
          end else begin
            w_nxt_state = S_PT;
            w_nxt_round = c_mid_round;
          end
        end
      end
      S_PT: begin
        if (r_round == c_last_round) begin
          w_nxt_state = S_PT_WAIT;
          w_nxt_round = c_first_round;
          if (r_block != c_last_block) begin
            w_nxt_block = r_block + 4'd1;
          end
        end else begin
          w_nxt_round = r_round + 4'd1;
        end
      end
      S_FIN: begin
        if (r_round == c_last_round) begin
          w_nxt_state = S_END;
          w_nxt_round = c_first_round;
        end else begin
          w_nxt_round = r_round + 4'd1;
        end
      end
      S_END: begin
        w_nxt_state = S_IDLE;
        w_nxt_round = c_first_round;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_round = c_first_round;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode of the next state (Moore: state and counters only)
  // --------------------------------------------------------------------------
  always_comb begin
    w_data_ready     = 1'b0;
    w_select         = 1'b0;
    w_enable         = 1'b0;
    w_xor_data_begin = 1'b0;
    w_xor_key_begin  = 1'b0;
    w_xor_key_end    = 1'b0;
    w_xor_ext_end    = 1'b0;
    w_round          = 4'd0;
    w_block          = 4'd0;
    w_cipher_valid   = 1'b0;
    w_tag_valid      = 1'b0;
    w_busy           = 1'b0;
    w_done           = 1'b0;
    case (w_nxt_state)
      S_INIT: begin
        w_busy        = 1'b1;
        w_enable      = 1'b1;
        w_round       = w_nxt_round;
        w_block       = w_nxt_block;
        w_select      = (w_nxt_round == c_first_round);
        w_xor_key_end = (w_nxt_round == c_last_round);
      end
      S_AD_WAIT, S_PT_WAIT: begin
        w_busy       = 1'b1;
        w_data_ready = 1'b1;
        w_block      = w_nxt_block;
      end
      S_AD: begin
        w_busy           = 1'b1;
        w_enable         = 1'b1;
        w_round          = w_nxt_round;
        w_block          = w_nxt_block;
        w_xor_data_begin = (w_nxt_round == c_mid_round);
        w_xor_ext_end    = (w_nxt_round == c_last_round);
      end
      S_PT: begin
        w_busy           = 1'b1;
        w_enable         = 1'b1;
        w_round          = w_nxt_round;
        w_block          = w_nxt_block;
        w_xor_data_begin = (w_nxt_round == c_mid_round);
        w_cipher_valid   = (w_nxt_round == c_mid_round);
      end
      S_FIN: begin
        w_busy           = 1'b1;
        w_enable         = 1'b1;
        w_round          = w_nxt_round;
        w_block          = w_nxt_block;
        w_xor_data_begin = (w_nxt_round == c_first_round);
        w_xor_key_begin  = (w_nxt_round == c_first_round);
        w_cipher_valid   = (w_nxt_round == c_first_round);
        w_xor_key_end    = (w_nxt_round == c_last_round);
      end
      S_END: begin
        w_busy      = 1'b1;
        w_block     = w_nxt_block;
        w_tag_valid = 1'b1;
        w_done      = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, counters and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state          <= S_IDLE;
      r_round          <= 4'd0;
      r_block          <= 4'd0;
      data_ready_o     <= 1'b0;
      select_o         <= 1'b0;
      enable_o         <= 1'b0;
      xor_data_begin_o <= 1'b0;
      xor_key_begin_o  <= 1'b0;
      xor_key_end_o    <= 1'b0;
      xor_ext_end_o    <= 1'b0;
      round_o          <= 4'd0;
      block_o          <= 4'd0;
      cipher_valid_o   <= 1'b0;
      tag_valid_o      <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
    end else begin
      r_state          <= w_nxt_state;
      r_round          <= w_nxt_round;
      r_block          <= w_nxt_block;
      data_ready_o     <= w_data_ready;
      select_o         <= w_select;
      enable_o         <= w_enable;
      xor_data_begin_o <= w_xor_data_begin;
      xor_key_begin_o  <= w_xor_key_begin;
      xor_key_end_o    <= w_xor_key_end;
      xor_ext_end_o    <= w_xor_ext_end;
      round_o          <= w_round;
      block_o          <= w_block;
      cipher_valid_o   <= w_cipher_valid;
      tag_valid_o      <= w_tag_valid;
      busy_o           <= w_busy;
      done_o           <= w_done;
    end
  end

endmodule
`default_nettype wire

// File: doc/ascon_fsm_ctrl.md
ASCON_FSM_CTRL -- requirements
Module: ascon_fsm_ctrl

Interface
REQ-001 SHALL have parameter NB_BLOCKS, default 4, giving total 64-bit plaintext blocks per message; legal range 2..15.
REQ-002 SHALL have port clock_i, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port resetb_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start_i, input, 1, begin one encryption; sampled only in IDLE.
REQ-005 SHALL have port data_valid_i, input, 1, AD/plaintext block present on datapath data bus.
REQ-006 SHALL have port data_ready_o, output, 1, controller accepts a block this cycle.
REQ-007 SHALL have port select_o, output, 1, 1 = datapath loads external initial state, 0 = register feedback.
REQ-008 SHALL have port enable_o, output, 1, state register enable.
REQ-009 SHALL have ports xor_data_begin_o, xor_key_begin_o, xor_key_end_o, xor_ext_end_o, output, 1 each, datapath XOR controls.
REQ-010 SHALL have port round_o, output, 4, round index for the permutation round constant.
REQ-011 SHALL have port block_o, output, 4, index of plaintext block being absorbed (0-based).
REQ-012 SHALL have ports cipher_valid_o, tag_valid_o, busy_o, done_o, output, 1 each.

Function
REQ-013 SHALL implement states IDLE, INIT, AD_WAIT, AD, PT_WAIT, PT, FIN, END.
REQ-014 IDLE: all outputs 0; start_i=1 -> INIT, round counter := 0, block counter := 0.
REQ-015 INIT: 12 cycles, round_o 0..11, enable_o=1; select_o=1 only on round 0; xor_key_end_o=1 only on round 11; then -> AD_WAIT.
REQ-016 AD_WAIT/PT_WAIT: enable_o=0, data_ready_o=1, round_o held 0; data_valid_i=1 -> next phase, else stay (no timeout).
REQ-017 AD: 6 cycles, round_o 6..11, enable_o=1; xor_data_begin_o=1 on round 6; xor_ext_end_o=1 on round 11; then -> PT_WAIT.
REQ-018 PT: 6 cycles, round_o 6..11; xor_data_begin_o=1 and cipher_valid_o=1 on round 6 only; block counter increments after round 11; -> PT_WAIT.
REQ-019 PT_WAIT with data_valid_i=1 SHALL go to FIN when block counter = NB_BLOCKS-1, else PT.
REQ-020 FIN: 12 cycles, round_o 0..11; round 0 asserts xor_data_begin_o, xor_key_begin_o, cipher_valid_o; round 11 asserts xor_key_end_o; then -> END.
REQ-021 END: one cycle, tag_valid_o=1, done_o=1, enable_o=0; unconditionally -> IDLE.
REQ-022 busy_o=1 in every state except IDLE; start_i outside IDLE SHALL be ignored.
REQ-023 round counter 4-bit, never exceeds 11; block counter saturates at NB_BLOCKS-1, cleared on IDLE->INIT.
REQ-024 All outputs SHALL be registered-state decodes (Moore); no combinational path from inputs to outputs except data_ready_o, which depends on state only.
REQ-025 block_o SHALL equal block counter; 0 during INIT/AD.

Reset
REQ-026 resetb_i=0 SHALL force IDLE, both counters 0, all outputs 0 immediately, regardless of state, including mid-round.
REQ-027 After reset release, first start_i SHALL yield a full sequence identical to a never-interrupted one.

Verification
REQ-028 NB_BLOCKS=4, start_i at edge 0, data_valid_i=1 always -> INIT cycles 1-12, AD 14-19, PT 21-26/28-33/35-40, FIN 42-53, tag_valid_o=done_o=1 at cycle 54 only, IDLE at 55.
REQ-029 Same, data_valid_i held 0 for 5 cycles in AD_WAIT -> data_ready_o=1 for 6 cycles, all later events shift by 5, enable_o=0 throughout wait.
REQ-030 Check per-round controls: select_o only cycle 1; xor_key_end_o cycles 12 and 53; xor_ext_end_o cycle 19; xor_data_begin_o cycles 14,21,28,35,42; cipher_valid_o 21,28,35,42; block_o = 0,1,2,3 at those PT/FIN starts.
REQ-031 resetb_i=0 asynchronously during PT round 8 -> outputs 0 before next edge, state IDLE; restart reproduces REQ-028 timing.
REQ-032 start_i pulsed during AD and during END -> no effect; sequence completes once, returns to IDLE, busy_o=0.
